// File: rtl/formula_result_credit_buffer.sv
// Credit-based flow-control shell around a fixed-latency, non-stallable pipe:
// issue slots are granted only against a reserved result FIFO entry.
module formula_result_credit_buffer #(
  parameter int DEPTH = 64,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_vld,
  output logic                     up_rdy,
  output logic                     issue_vld,
  input  logic                     in_vld,
  input  logic [W-1:0]             in_data,
  output logic                     out_vld,
  output logic [W-1:0]             out_data,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   credits_used,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] reserved;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] occupancy;
  logic [W-1:0]  mem [DEPTH];

  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic push_drop;

  // Pointers carry one extra bit so full (MSBs differ) and empty are distinct.
  assign occupancy  = wr_ptr - rd_ptr;
  assign rd_ptr_nxt = rd_ptr + PW'(1);
  assign full       = (occupancy == PW'(DEPTH));
  assign empty      = (occupancy == '0);

  assign up_rdy       = (reserved < PW'(DEPTH));
  assign issue_vld    = up_vld & up_rdy;
  assign out_vld      = ~empty;
  assign pop          = out_vld & out_rdy;
  assign push_ok      = in_vld & (~full | pop);
  assign push_drop    = in_vld & full & ~pop;
  assign credits_used = reserved;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      reserved <= '0;
    end else if (issue_vld && !pop) begin
      reserved <= reserved + PW'(1);
    end else if (pop && !issue_vld) begin
      reserved <= reserved - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)   wr_ptr   <= wr_ptr + PW'(1);
      if (pop)       rd_ptr   <= rd_ptr_nxt;
      if (push_drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // after a push, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  // Registered head: loaded on a push into an empty FIFO, or advanced on pop.
  // When the entry behind the head is the one being written this cycle, it is
  // taken straight from in_data since the array write has not landed yet.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_ok && empty) begin
        out_data <= in_data;
      end else if (pop && occupancy > PW'(1)) begin
        out_data <= mem[rd_ptr_nxt[AW-1:0]];
      end else if (pop && push_ok) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_formula_result_credit_buffer.sv
// Bench: DEPTH=4 instance driven by vector table and hand sequences, DEPTH=64
// instance fed by a 50-cycle pipe stand-in and checked against a queue model.
module tb_formula_result_credit_buffer;

  localparam int LAT = 50;
  localparam int D64 = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- DEPTH = 4 instance ----------------
  logic        rst4 = 1'b1, up4 = 1'b0, in4 = 1'b0, ordy4 = 1'b0;
  logic [31:0] din4 = '0;
  logic        up_rdy4, issue4, ovld4, ovf4;
  logic [31:0] odata4;
  logic [2:0]  cred4;

  formula_result_credit_buffer #(.DEPTH(4), .W(32)) dut4 (
    .clk(clk), .rst(rst4), .up_vld(up4), .up_rdy(up_rdy4), .issue_vld(issue4),
    .in_vld(in4), .in_data(din4), .out_vld(ovld4), .out_data(odata4),
    .out_rdy(ordy4), .credits_used(cred4), .overflow(ovf4)
  );

  // ---------------- DEPTH = 64 instance ----------------
  logic        rst64 = 1'b1, up64 = 1'b0, ordy64 = 1'b0;
  logic        in64;
  logic [31:0] din64;
  logic        up_rdy64, issue64, ovld64, ovf64;
  logic [31:0] odata64;
  logic [6:0]  cred64;
  logic [31:0] a64 = '0, b64 = '0, c64 = '0;

  formula_result_credit_buffer #(.DEPTH(D64), .W(32)) dut64 (
    .clk(clk), .rst(rst64), .up_vld(up64), .up_rdy(up_rdy64), .issue_vld(issue64),
    .in_vld(in64), .in_data(din64), .out_vld(ovld64), .out_data(odata64),
    .out_rdy(ordy64), .credits_used(cred64), .overflow(ovf64)
  );

  function automatic logic [31:0] formula(input logic [31:0] a, b, c);
    return a * b + c;
  endfunction

  // Stand-in for formula_2_pipe: fixed latency, no backpressure, reset with the block.
  logic        pipe_v [LAT];
  logic [31:0] pipe_d [LAT];
  always @(posedge clk) begin
    if (rst64) begin
      for (int k = 0; k < LAT; k++) pipe_v[k] <= 1'b0;
    end else begin
      pipe_v[0] <= issue64;
      pipe_d[0] <= formula(a64, b64, c64);
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_d[k] <= pipe_d[k-1];
      end
    end
  end
  assign in64  = pipe_v[LAT-1];
  assign din64 = pipe_d[LAT-1];

  // Behavioural model of the DEPTH=64 buffer.
  logic [31:0] m_q[$];
  logic [31:0] f_q[$];
  int          m_res = 0;
  logic        m_ovf = 1'b0;

  task automatic reset64();
    @(negedge clk);
    rst64 = 1'b1; up64 = 1'b0; ordy64 = 1'b0;
    @(negedge clk);
    rst64 = 1'b0;
    m_q.delete(); f_q.delete(); m_res = 0; m_ovf = 1'b0;
  endtask

  task automatic run_cycle(input logic up, input logic ordy,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                           output logic did_pop);
    logic exp_rdy, issue, pop, push, was_full;
    @(negedge clk);
    up64 = up; ordy64 = ordy; a64 = a; b64 = b; c64 = c;
    #1;
    exp_rdy = (m_res < D64);
    issue   = up && exp_rdy;
    pop     = ordy && (m_q.size() > 0);
    push    = in64;
    check("up_rdy", up_rdy64, exp_rdy);
    check("issue_vld", issue64, issue);
    check("out_vld", ovld64, m_q.size() > 0);
    check("credits_used", cred64, m_res);
    check("overflow", ovf64, m_ovf);
    if (m_q.size() > 0) check("out_data", odata64, m_q[0]);
    if (pop) check("order_vs_formula", odata64, (f_q.size() > 0) ? f_q[0] : 32'hDEAD_BEEF);
    was_full = (m_q.size() == D64);
    if (pop) begin
      void'(m_q.pop_front());
      if (f_q.size() > 0) void'(f_q.pop_front());
    end
    if (push) begin
      if (was_full && !pop) m_ovf = 1'b1;
      else m_q.push_back(din64);
    end
    if (issue) f_q.push_back(formula(a, b, c));
    m_res = m_res + int'(issue) - int'(pop);
    did_pop = pop;
  endtask

  // ---------------- vector table for DEPTH = 4 ----------------
  typedef struct {
    logic        up, in_v;
    logic [31:0] din;
    logic        ordy;
    logic        e_up_rdy, e_issue, e_ovld;
    logic [31:0] e_odata;
    logic [2:0]  e_cred;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(input int up, in_v, din, ordy, e_rdy, e_iss, e_ov, e_od, e_cr, e_of);
    vec_t v;
    v.up = up[0]; v.in_v = in_v[0]; v.din = 32'(din); v.ordy = ordy[0];
    v.e_up_rdy = e_rdy[0]; v.e_issue = e_iss[0]; v.e_ovld = e_ov[0];
    v.e_odata = 32'(e_od); v.e_cred = 3'(e_cr); v.e_ovf = e_of[0];
    return v;
  endfunction

  task automatic drive4(input logic up, input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    up4 = up; in4 = iv; din4 = d; ordy4 = ordy;
    #1;
  endtask

  vec_t tbl[16];
  logic did_pop;
  int   pops;
  logic rdy_dropped;

  initial begin
    // Back-pressure fill, overflow attempt, then drain.
    tbl[0]  = mk(1, 0, 0,    0, 1, 1, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0,    0, 1, 1, 0, 0, 1, 0);
    tbl[2]  = mk(1, 0, 0,    0, 1, 1, 0, 0, 2, 0);
    tbl[3]  = mk(1, 0, 0,    0, 1, 1, 0, 0, 3, 0);
    tbl[4]  = mk(1, 0, 0,    0, 0, 0, 0, 0, 4, 0);
    tbl[5]  = mk(1, 1, 1,    0, 0, 0, 0, 0, 4, 0);
    tbl[6]  = mk(1, 1, 2,    0, 0, 0, 1, 1, 4, 0);
    tbl[7]  = mk(1, 1, 3,    0, 0, 0, 1, 1, 4, 0);
    tbl[8]  = mk(1, 1, 4,    0, 0, 0, 1, 1, 4, 0);
    tbl[9]  = mk(1, 1, 'hFF, 0, 0, 0, 1, 1, 4, 0);
    tbl[10] = mk(0, 0, 0,    0, 0, 0, 1, 1, 4, 1);
    tbl[11] = mk(1, 0, 0,    1, 0, 0, 1, 1, 4, 1);
    tbl[12] = mk(1, 0, 0,    1, 1, 1, 1, 2, 3, 1);
    tbl[13] = mk(0, 0, 0,    1, 1, 0, 1, 3, 3, 1);
    tbl[14] = mk(0, 0, 0,    1, 1, 0, 1, 4, 2, 1);
    tbl[15] = mk(0, 0, 0,    0, 1, 0, 0, 0, 1, 1);

    // Reset, then idle: reset state on the DEPTH=4 instance.
    repeat (2) @(negedge clk);
    rst4 = 1'b0;
    for (int i = 0; i < 5; i++) drive4(0, 0, 0, 0);
    check("rst4_out_vld", ovld4, 0);
    check("rst4_up_rdy", up_rdy4, 1);
    check("rst4_credits", cred4, 0);
    check("rst4_overflow", ovf4, 0);

    for (int i = 0; i < 16; i++) begin
      drive4(tbl[i].up, tbl[i].in_v, tbl[i].din, tbl[i].ordy);
      check($sformatf("vec%0d_up_rdy", i), up_rdy4, tbl[i].e_up_rdy);
      check($sformatf("vec%0d_issue", i), issue4, tbl[i].e_issue);
      check($sformatf("vec%0d_out_vld", i), ovld4, tbl[i].e_ovld);
      if (tbl[i].e_ovld) check($sformatf("vec%0d_out_data", i), odata4, tbl[i].e_odata);
      check($sformatf("vec%0d_credits", i), cred4, tbl[i].e_cred);
      check($sformatf("vec%0d_overflow", i), ovf4, tbl[i].e_ovf);
    end

    // Reset clears sticky overflow and counters.
    @(negedge clk); rst4 = 1'b1; up4 = 0; in4 = 0; ordy4 = 0;
    @(negedge clk); rst4 = 1'b0; #1;
    check("rst4b_overflow", ovf4, 0);
    check("rst4b_credits", cred4, 0);
    check("rst4b_out_vld", ovld4, 0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) drive4(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive4(0, 1, 32'hA + 32'(i), 0);
    drive4(0, 1, 32'hE, 1);
    check("full_pp_out_vld", ovld4, 1);
    check("full_pp_head", odata4, 32'hA);
    for (int i = 0; i < 4; i++) begin
      drive4(0, 0, 0, 1);
      check($sformatf("full_pp_out_vld%0d", i), ovld4, 1);
      check($sformatf("full_pp_data%0d", i), odata4, 32'hB + 32'(i));
    end
    drive4(0, 0, 0, 0);
    check("full_pp_empty", ovld4, 0);
    check("full_pp_overflow", ovf4, 0);

    // ---------------- DEPTH = 64 instance ----------------
    reset64();
    for (int i = 0; i < 5; i++) run_cycle(0, 0, 0, 0, 0, did_pop);
    check("rst64_out_vld", ovld64, 0);
    check("rst64_up_rdy", up_rdy64, 1);
    check("rst64_credits", cred64, 0);

    // Single beat: issue at cycle 0 yields result 7 at cycle 50, popped at 51.
    run_cycle(1, 1, 0, 0, 7, did_pop);
    for (int i = 1; i <= 52; i++) begin
      run_cycle(0, 1, 0, 0, 0, did_pop);
      if (i == 51) begin
        check("single_out_vld", ovld64, 1);
        check("single_out_data", odata64, 32'h7);
        check("single_credits_before", cred64, 1);
      end
      if (i == 52) begin
        check("single_credits_after", cred64, 0);
        check("single_empty", ovld64, 0);
      end
    end

    // Streaming: 200 back-to-back issues with an always-ready consumer.
    pops = 0;
    rdy_dropped = 1'b0;
    for (int i = 0; i < 200; i++) begin
      run_cycle(1, 1, $urandom, $urandom, $urandom, did_pop);
      if (!up_rdy64) rdy_dropped = 1'b1;
      pops += int'(did_pop);
    end
    for (int i = 0; i < LAT + 10; i++) begin
      run_cycle(0, 1, 0, 0, 0, did_pop);
      pops += int'(did_pop);
    end
    check("stream_up_rdy_never_dropped", rdy_dropped, 0);
    check("stream_beats_out", pops, 200);
    check("stream_overflow", ovf64, 0);

    // Random traffic with a slow, bursty consumer.
    for (int i = 0; i < 1500; i++)
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0 && (i % 300) < 200),
                $urandom, $urandom, $urandom, did_pop);
    for (int i = 0; i < D64 + LAT + 20; i++) run_cycle(0, 1, 0, 0, 0, did_pop);
    check("rand_drained_out_vld", ovld64, 0);
    check("rand_drained_credits", cred64, 0);
    check("rand_overflow", ovf64, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
